mips_register_file: RTL and testbench

- General-purpose register file of the single-cycle MIPS datapath.
- Sits directly downstream of the write-back data select mux (ALU result vs. memory read data). That mux output drives WD3.
- Supplies the two source operands to the ALU-input / branch-compare stage.
- Adds a registered debug read port for the Nexys4 DDR seven-segment display, plus a saturating retired-write counter.

---
 rtl/mips_register_file.sv | 89 ++++++++
 tb/tb_mips_register_file.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_register_file.sv
// rtl/mips_register_file.sv - MIPS general-purpose register file with registered debug port and saturating write counter; REGFILE_WRITE_BYPASS_EN adds WD3->RD1/RD2 bypass
module mips_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WE3,
  input  logic [ADDR_WIDTH-1:0] A1,
  input  logic [ADDR_WIDTH-1:0] A2,
  input  logic [ADDR_WIDTH-1:0] A3,
  input  logic [DATA_WIDTH-1:0] WD3,
  output logic [DATA_WIDTH-1:0] RD1,
  output logic [DATA_WIDTH-1:0] RD2,
  input  logic [ADDR_WIDTH-1:0] DBG_ADDR,
  output logic [DATA_WIDTH-1:0] DBG_DATA,
  output logic [CNT_WIDTH-1:0]  WR_COUNT
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic [DATA_WIDTH-1:0] dbg_data_q, dbg_data_d;
  logic [CNT_WIDTH-1:0]  wr_count_q, wr_count_d;

  // A write only retires when enabled and not aimed at the hardwired zero register
  logic write_fire;
  assign write_fire = WE3 && (A3 != '0);

  // Next-state for the array, the debug snapshot and the retired-write counter
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (write_fire) begin
      regs_d[A3] = WD3;
    end
    // Entry 0 is constant zero so synthesis can trim it
    regs_d[0] = '0;

    // Snapshot taken from pre-write contents; the debug port never sees the bypass
    dbg_data_d = (DBG_ADDR == '0) ? '0 : regs_q[DBG_ADDR];

    wr_count_d = wr_count_q;
    if (write_fire && (wr_count_q != {CNT_WIDTH{1'b1}})) begin
      wr_count_d = wr_count_q + CNT_WIDTH'(1);
    end
  end

  // State update; reset wins over a same-cycle write, which is dropped and not counted
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      dbg_data_q <= '0;
      wr_count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      dbg_data_q <= dbg_data_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Zero-latency operand reads for the single-cycle datapath
  always_comb begin
    RD1 = (A1 == '0) ? '0 : regs_q[A1];
    RD2 = (A2 == '0) ? '0 : regs_q[A2];
`ifdef REGFILE_WRITE_BYPASS_EN
    // Forward the in-flight write so decode sees the value write-back is producing
    if (!RST && write_fire && (A3 == A1)) begin
      RD1 = WD3;
    end
    if (!RST && write_fire && (A3 == A2)) begin
      RD2 = WD3;
    end
`else
    // Stored contents only: reads show the old value until the edge commits the write
`endif
  end

  assign DBG_DATA = dbg_data_q;
  assign WR_COUNT = wr_count_q;

endmodule

// File: tb/tb_mips_register_file.sv
// tb/tb_mips_register_file.sv - self-checking bench for mips_register_file (default and CNT_WIDTH=4 instances)
module tb_mips_register_file;

  logic        CLK;
  logic        RST;
  logic        WE3;
  logic [4:0]  A1, A2, A3, DBG_ADDR;
  logic [31:0] WD3;
  logic [31:0] RD1, RD2, DBG_DATA;
  logic [15:0] WR_COUNT;
  logic [31:0] RD1_s, RD2_s, DBG_DATA_s;
  logic [3:0]  WR_COUNT_s;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // Reference state: what the register file must hold according to its rules
  logic [31:0] m_mem [32];
  logic [31:0] m_dbg;
  int          m_cnt;
  int          m_cnt4;

  mips_register_file dut (
    .CLK(CLK), .RST(RST), .WE3(WE3), .A1(A1), .A2(A2), .A3(A3), .WD3(WD3),
    .RD1(RD1), .RD2(RD2), .DBG_ADDR(DBG_ADDR), .DBG_DATA(DBG_DATA), .WR_COUNT(WR_COUNT)
  );

  mips_register_file #(.CNT_WIDTH(4)) dut_small (
    .CLK(CLK), .RST(RST), .WE3(WE3), .A1(A1), .A2(A2), .A3(A3), .WD3(WD3),
    .RD1(RD1_s), .RD2(RD2_s), .DBG_ADDR(DBG_ADDR), .DBG_DATA(DBG_DATA_s), .WR_COUNT(WR_COUNT_s)
  );

  initial CLK = 0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
`ifdef REGFILE_WRITE_BYPASS_EN
    if (!RST && WE3 && A3 == a) return WD3;
`endif
    return m_mem[a];
  endfunction

  // Model update at each rising edge
  always @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
      m_dbg = 0; m_cnt = 0; m_cnt4 = 0;
    end else begin
      m_dbg = (DBG_ADDR == 0) ? 32'h0 : m_mem[DBG_ADDR];
      if (WE3 && A3 != 0) begin
        m_mem[A3] = WD3;
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
    end
  end

  // Continuous comparison against the model, away from the active edge
  always @(negedge CLK) begin
    if (chk_en) begin
      check("rd1", RD1, exp_read(A1));
      check("rd2", RD2, exp_read(A2));
      check("dbg", DBG_DATA, m_dbg);
      check("wr_count", {16'h0, WR_COUNT}, m_cnt);
      check("rd1_small", RD1_s, exp_read(A1));
      check("wr_count_small", {28'h0, WR_COUNT_s}, m_cnt4);
    end
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic drive(input logic we, input logic [4:0] a3, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] dbg);
    WE3 = we; A3 = a3; WD3 = wd; A1 = a1; A2 = a2; DBG_ADDR = dbg;
  endtask

  initial begin
    RST = 1;
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk_en = 1;
    step();
    RST = 0;
    drive(0, 0, 0, 8, 9, 0);
    #1;
    check("reset_rd1", RD1, 32'h0);
    check("reset_count", {16'h0, WR_COUNT}, 32'd0);
    check("reset_dbg", DBG_DATA, 32'h0);

    // Write r8 then read it back
    drive(1, 8, 32'hDEADBEEF, 0, 0, 0);
    step();
    drive(0, 8, 32'h0, 8, 0, 0);
    #1;
    check("r8_read", RD1, 32'hDEADBEEF);
    check("r8_count", {16'h0, WR_COUNT}, 32'd1);

    // Write to r0 is discarded
    drive(1, 0, 32'h12345678, 0, 0, 0);
    step();
    drive(0, 0, 32'h0, 0, 0, 0);
    #1;
    check("r0_rd1", RD1, 32'h0);
    check("r0_rd2", RD2, 32'h0);
    check("r0_count", {16'h0, WR_COUNT}, 32'd1);

    // WE3=0 with a live address changes nothing
    drive(0, 8, 32'hFFFFFFFF, 8, 8, 0);
    step();
    #1;
    check("we0_hold", RD1, 32'hDEADBEEF);

    // Same-cycle read/write of r5
    drive(1, 5, 32'h11, 0, 0, 0);
    step();
    drive(1, 5, 32'h22, 5, 5, 0);
    #1;
`ifdef REGFILE_WRITE_BYPASS_EN
    check("rdw_before_rd1", RD1, 32'h22);
    check("rdw_before_rd2", RD2, 32'h22);
`else
    check("rdw_before_rd1", RD1, 32'h11);
    check("rdw_before_rd2", RD2, 32'h11);
`endif
    step();
    drive(0, 0, 32'h0, 5, 5, 0);
    #1;
    check("rdw_after_rd1", RD1, 32'h22);
    check("rdw_after_rd2", RD2, 32'h22);
    check("rdw_count", {16'h0, WR_COUNT}, 32'd3);

    // Debug port: same-edge write is not visible, one-edge latency
    drive(1, 31, 32'hA5A5A5A5, 8, 5, 31);
    step();
    drive(0, 0, 32'h0, 8, 5, 31);
    #1;
    check("dbg_prewrite", DBG_DATA, 32'h0);
    step();
    #1;
    check("dbg_r31", DBG_DATA, 32'hA5A5A5A5);
    DBG_ADDR = 0;
    #1;
    check("dbg_hold", DBG_DATA, 32'hA5A5A5A5);
    step();
    #1;
    check("dbg_r0", DBG_DATA, 32'h0);

    // Mixed traffic on distinct registers
    for (int i = 2; i < 7; i++) begin
      drive(1, 5'(i), 32'h1000 * i + 32'h3, 5'(i - 1), 5'(i + 1), 5'(i - 1));
      step();
    end
    drive(0, 0, 32'h0, 4, 6, 0);
    #1;
    check("mix_rd1", RD1, 32'h4003);
    check("mix_rd2", RD2, 32'h6003);

    // Reset together with a write: the write is lost
    RST = 1;
    drive(1, 3, 32'h7, 3, 8, 31);
    step();
    RST = 0;
    drive(0, 0, 32'h0, 3, 8, 31);
    #1;
    check("rst_wr_rd1", RD1, 32'h0);
    check("rst_wr_rd2", RD2, 32'h0);
    check("rst_wr_count", {16'h0, WR_COUNT}, 32'd0);
    check("rst_wr_dbg", DBG_DATA, 32'h0);

    // 20 writes to r1: small counter saturates at 0xF
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 32'(i), 1, 0, 1);
      step();
    end
    drive(0, 0, 32'h0, 1, 0, 1);
    #1;
    check("sat_small", {28'h0, WR_COUNT_s}, 32'hF);
    check("sat_wide", {16'h0, WR_COUNT}, 32'd20);
    check("sat_r1", RD1, 32'd19);
    drive(1, 1, 32'h55, 1, 0, 1);
    step();
    drive(0, 0, 32'h0, 1, 0, 1);
    step();
    #1;
    check("sat_small_hold", {28'h0, WR_COUNT_s}, 32'hF);
    check("sat_wide_next", {16'h0, WR_COUNT}, 32'd21);

    chk_en = 0;
    #10;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
